// File: rtl/matmul_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matmul_pkg                                                               |
// | Shared sizes, matrix types and FSM encoding for the matmul engine.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package matmul_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int BUS_WIDTH  = 32;
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
  localparam int DIM_W      = $clog2(MAX_DIM) + 1;
  // Wide enough for the longest run: MAX_DIM + 2*(MAX_DIM-1) cycles
  localparam int T_W        = $clog2(3 * MAX_DIM);

  typedef logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0] matA;
  typedef logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0] matB;
  typedef logic [MAX_DIM-1:0][MAX_DIM-1:0][BUS_WIDTH-1:0]  matc;
  typedef logic [MAX_DIM*MAX_DIM-1:0]                      ovf_vec_t;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} mm_state_e;

  function automatic logic dim_ok(input logic [DIM_W-1:0] d);
    return (d != '0) && (d <= DIM_W'(MAX_DIM));
  endfunction
endpackage
`default_nettype wire

// File: rtl/matmul_systolic_engine_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matmul_systolic_engine_if                                                |
// | Command, operand and result bundle between front-end and engine.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface matmul_systolic_engine_if;
  import matmul_pkg::*;

  logic             start_i;
  logic [DIM_W-1:0] n_dim_i;
  logic [DIM_W-1:0] k_dim_i;
  logic [DIM_W-1:0] m_dim_i;
  logic             signed_i;
  logic             bias_en_i;
  matA              a_i;
  matB              b_i;
  matc              bias_i;
  matc              c_o;
  ovf_vec_t         ovf_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  modport master (
    output start_i, n_dim_i, k_dim_i, m_dim_i, signed_i, bias_en_i, a_i, b_i, bias_i,
    input  c_o, ovf_o, busy_o, done_o, err_o
  );

  modport slave (
    input  start_i, n_dim_i, k_dim_i, m_dim_i, signed_i, bias_en_i, a_i, b_i, bias_i,
    output c_o, ovf_o, busy_o, done_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/matmul_pe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matmul_pe                                                                |
// | One output-stationary MAC cell with a/b forwarding and sticky overflow.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module matmul_pe
  import matmul_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic                  i_signed,
  input  logic [BUS_WIDTH-1:0]  i_init,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_a,
  output logic [DATA_WIDTH-1:0] o_b,
  output logic [BUS_WIDTH-1:0]  o_acc,
  output logic                  o_ovf
);
  logic [DATA_WIDTH-1:0]          r_a;
  logic [DATA_WIDTH-1:0]          r_b;
  logic [BUS_WIDTH-1:0]           r_acc;
  logic                           r_ovf;
  logic signed [2*DATA_WIDTH-1:0] w_sprod;
  logic [2*DATA_WIDTH-1:0]        w_uprod;
  logic [BUS_WIDTH:0]             w_prod_x;
  logic [BUS_WIDTH:0]             w_acc_x;
  logic [BUS_WIDTH:0]             w_sum;
  logic                           w_ovf;

  assign w_sprod = $signed(i_a) * $signed(i_b);
  assign w_uprod = i_a * i_b;

  // One guard bit above the accumulator exposes the true sum for the range check
  always_comb begin
    if (i_signed) begin
      w_prod_x = {{(BUS_WIDTH+1-2*DATA_WIDTH){w_sprod[2*DATA_WIDTH-1]}}, w_sprod};
      w_acc_x  = {r_acc[BUS_WIDTH-1], r_acc};
    end else begin
      w_prod_x = {{(BUS_WIDTH+1-2*DATA_WIDTH){1'b0}}, w_uprod};
      w_acc_x  = {1'b0, r_acc};
    end
    w_sum = w_acc_x + w_prod_x;
    w_ovf = i_signed ? (w_sum[BUS_WIDTH] ^ w_sum[BUS_WIDTH-1]) : w_sum[BUS_WIDTH];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= i_init;
      r_ovf <= 1'b0;
    end else if (i_en) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= w_sum[BUS_WIDTH-1:0];
      r_ovf <= r_ovf | w_ovf;
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_acc = r_acc;
  assign o_ovf = r_ovf;
endmodule
`default_nettype wire

// File: rtl/matmul_systolic_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matmul_systolic_engine                                                   |
// | Runtime-dimensioned C = A*B [+bias] on an output-stationary PE grid.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module matmul_systolic_engine
  import matmul_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  matmul_systolic_engine_if.slave bus
);
  localparam logic [T_W-1:0] c_tail = T_W'(2 * (MAX_DIM - 1) - 1);

  mm_state_e             r_state;
  logic [T_W-1:0]        r_t;
  logic [DIM_W-1:0]      r_n;
  logic [DIM_W-1:0]      r_k;
  logic [DIM_W-1:0]      r_m;
  logic                  r_signed;
  logic                  r_bias_en;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  matA                   r_a;
  matB                   r_b;
  logic                  w_legal;
  logic [T_W-1:0]        w_t_last;
  logic [DATA_WIDTH-1:0] w_a_feed [MAX_DIM];
  logic [DATA_WIDTH-1:0] w_b_feed [MAX_DIM];
  logic [DATA_WIDTH-1:0] w_a_pipe [MAX_DIM][MAX_DIM];
  logic [DATA_WIDTH-1:0] w_b_pipe [MAX_DIM][MAX_DIM];
  matc                   w_acc;
  ovf_vec_t              w_ovf;

  assign w_legal  = dim_ok(bus.n_dim_i) && dim_ok(bus.k_dim_i) && dim_ok(bus.m_dim_i);
  assign w_t_last = T_W'(r_k) + c_tail;

  // Skewed edge feed: row i sees A[i][t-i], column j sees B[t-j][j], zero outside 0..k-1
  always_comb begin
    for (int i = 0; i < MAX_DIM; i++) begin
      w_a_feed[i] = '0;
      w_b_feed[i] = '0;
      for (int kk = 0; kk < MAX_DIM; kk++) begin
        if ((DIM_W'(kk) < r_k) && (r_t == T_W'(kk + i))) begin
          w_a_feed[i] = r_a[i][kk];
          w_b_feed[i] = r_b[kk][i];
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < MAX_DIM; i++) begin : g_row
      for (genvar j = 0; j < MAX_DIM; j++) begin : g_col
        logic [DATA_WIDTH-1:0] w_a_in;
        logic [DATA_WIDTH-1:0] w_b_in;
        logic [BUS_WIDTH-1:0]  w_init;
        logic                  w_inside;

        if (j == 0) begin : g_a_edge
          assign w_a_in = w_a_feed[i];
        end else begin : g_a_chain
          assign w_a_in = w_a_pipe[i][j-1];
        end
        if (i == 0) begin : g_b_edge
          assign w_b_in = w_b_feed[j];
        end else begin : g_b_chain
          assign w_b_in = w_b_pipe[i-1][j];
        end

        assign w_inside = (DIM_W'(i) < r_n) && (DIM_W'(j) < r_m);
        assign w_init   = (r_bias_en && w_inside) ? bus.bias_i[i][j] : '0;

        matmul_pe u_pe (
          .clk_i    (clk_i),
          .rst_ni   (rst_ni),
          .i_clr    (r_state == LOAD),
          .i_en     (r_state == RUN),
          .i_signed (r_signed),
          .i_init   (w_init),
          .i_a      (w_a_in),
          .i_b      (w_b_in),
          .o_a      (w_a_pipe[i][j]),
          .o_b      (w_b_pipe[i][j]),
          .o_acc    (w_acc[i][j]),
          .o_ovf    (w_ovf[i*MAX_DIM+j])
        );

        // Accumulators only move in LOAD/RUN, so the masked view is stable from DONE to next LOAD
        assign bus.c_o[i][j]             = w_inside ? w_acc[i][j] : '0;
        assign bus.ovf_o[i*MAX_DIM + j]  = w_inside & w_ovf[i*MAX_DIM+j];
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_t       <= '0;
      r_n       <= '0;
      r_k       <= '0;
      r_m       <= '0;
      r_signed  <= 1'b0;
      r_bias_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start_i) begin
            r_busy <= 1'b1;
            if (w_legal) begin
              r_state   <= LOAD;
              r_n       <= bus.n_dim_i;
              r_k       <= bus.k_dim_i;
              r_m       <= bus.m_dim_i;
              r_signed  <= bus.signed_i;
              r_bias_en <= bus.bias_en_i;
              r_err     <= 1'b0;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        LOAD: begin
          r_a     <= bus.a_i;
          r_b     <= bus.b_i;
          r_t     <= '0;
          r_state <= RUN;
        end
        RUN: begin
          if (r_t == w_t_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_t <= r_t + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o = r_busy;
  assign bus.done_o = r_done;
  assign bus.err_o  = r_err;
endmodule
`default_nettype wire

// File: tb/tb_matmul_systolic_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_matmul_systolic_engine                                                |
// | Directed vectors with a queue scoreboard checked on every done_o pulse.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_matmul_systolic_engine;
  import matmul_pkg::*;

  typedef struct {
    matc      c;
    ovf_vec_t ovf;
    logic     err;
    int       done_cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];

  matmul_systolic_engine_if ifc();

  matmul_systolic_engine dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && ifc.done_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("c_o", ifc.c_o, e.c);
        chk("ovf_o", ifc.ovf_o, e.ovf);
        chk("err_o", ifc.err_o, e.err);
        if (e.done_cyc >= 0) chk("done_cycle", cyc, e.done_cyc);
      end
    end
  end

  task automatic run_op(input int n, input int k, input int m, input logic sg, input logic be,
                        input matA a, input matB b, input matc bias,
                        input matc ec, input ovf_vec_t eo, input logic ee, input logic poke);
    exp_t e;
    int   s;
    int   cnt;
    int   guard;
    logic legal;
    legal = (n >= 1 && n <= MAX_DIM) && (k >= 1 && k <= MAX_DIM) && (m >= 1 && m <= MAX_DIM);
    @(negedge clk);
    ifc.n_dim_i   = DIM_W'(n);
    ifc.k_dim_i   = DIM_W'(k);
    ifc.m_dim_i   = DIM_W'(m);
    ifc.signed_i  = sg;
    ifc.bias_en_i = be;
    ifc.a_i       = a;
    ifc.b_i       = b;
    ifc.bias_i    = bias;
    ifc.start_i   = 1'b1;
    s = cyc;
    e.c = ec;
    e.ovf = eo;
    e.err = ee;
    e.done_cyc = legal ? s + 2 + k + 2 * (MAX_DIM - 1) : -1;
    sb.push_back(e);
    @(negedge clk);
    ifc.start_i = 1'b0;
    cnt = 0;
    guard = 0;
    while (ifc.busy_o && guard < 100) begin
      cnt++;
      if (poke && ifc.done_o) ifc.start_i = 1'b1;
      @(negedge clk);
      ifc.start_i = 1'b0;
      guard++;
    end
    chk("busy_cycles", cnt, legal ? k + 2 * MAX_DIM : 1);
    if (poke) begin
      repeat (2) begin
        @(negedge clk);
        chk("start_in_done_ignored", ifc.busy_o, 1'b0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    matA a1, a;
    matB b1, b;
    matc z, ec1, ec, bias;
    z = '0;
    ifc.start_i = 1'b0; ifc.n_dim_i = '0; ifc.k_dim_i = '0; ifc.m_dim_i = '0;
    ifc.signed_i = 1'b0; ifc.bias_en_i = 1'b0;
    ifc.a_i = '0; ifc.b_i = '0; ifc.bias_i = '0;

    repeat (2) @(negedge clk);
    chk("rst_c", ifc.c_o, z);
    chk("rst_ovf", ifc.ovf_o, 0);
    chk("rst_busy", ifc.busy_o, 0);
    chk("rst_done", ifc.done_o, 0);
    chk("rst_err", ifc.err_o, 0);
    rst_n = 1'b1;

    // Test 1: rows beyond n and columns beyond m carry data that must be masked
    a1 = '0; b1 = '0; ec1 = '0;
    for (int kk = 0; kk < 4; kk++) begin
      a1[0][kk] = 8'(kk + 1);
      a1[1][kk] = 8'(kk + 5);
      a1[2][kk] = 8'd9;
      a1[3][kk] = 8'd9;
      b1[kk][0] = 8'd1;
      b1[kk][1] = 8'd1;
    end
    ec1[0][0] = 32'd10;
    ec1[1][0] = 32'd26;
    run_op(2, 4, 1, 1'b0, 1'b0, a1, b1, z, ec1, '0, 1'b0, 1'b0);

    // Test 2: identity times B gives B, then again with a start during DONE
    a = '0; b = '0; ec = '0;
    for (int i = 0; i < 4; i++) begin
      a[i][i] = 8'd1;
      for (int j = 0; j < 4; j++) begin
        b[i][j]  = 8'(i * 4 + j);
        ec[i][j] = 32'(i * 4 + j);
      end
    end
    run_op(4, 4, 4, 1'b0, 1'b0, a, b, z, ec, '0, 1'b0, 1'b0);
    run_op(4, 4, 4, 1'b1, 1'b0, a, b, z, ec, '0, 1'b0, 1'b1);

    // Test 3: 0xFF * 2 signed and unsigned
    a = '0; b = '0; ec = '0;
    a[0][0] = 8'hFF;
    b[0][0] = 8'h02;
    ec[0][0] = 32'hFFFF_FFFE;
    run_op(1, 1, 1, 1'b1, 1'b0, a, b, z, ec, '0, 1'b0, 1'b0);
    ec[0][0] = 32'd510;
    run_op(1, 1, 1, 1'b0, 1'b0, a, b, z, ec, '0, 1'b0, 1'b0);

    // Test 4: bias overflow in both modes, then a clean op clears ovf
    a = '0; b = '0; bias = '0; ec = '0;
    a[0][0] = 8'd1;
    b[0][0] = 8'd1;
    bias[0][0] = 32'h7FFF_FFFF;
    bias[1][1] = 32'h0000_1234;
    ec[0][0] = 32'h8000_0000;
    run_op(1, 1, 1, 1'b1, 1'b1, a, b, bias, ec, 16'h0001, 1'b0, 1'b0);
    bias[0][0] = 32'hFFFF_FFFF;
    ec[0][0] = 32'h0;
    run_op(1, 1, 1, 1'b0, 1'b1, a, b, bias, ec, 16'h0001, 1'b0, 1'b0);
    a[0][0] = 8'd3;
    b[0][0] = 8'd4;
    ec[0][0] = 32'd12;
    run_op(1, 1, 1, 1'b1, 1'b0, a, b, bias, ec, '0, 1'b0, 1'b0);

    // Test 5: illegal dims leave the previous result in place and flag err
    run_op(0, 5, 1, 1'b0, 1'b0, a1, b1, z, ec, '0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("err_held", ifc.err_o, 1'b1);

    // Test 6: reset during RUN at t=3 aborts with no done
    @(negedge clk);
    ifc.n_dim_i = 3'd2; ifc.k_dim_i = 3'd4; ifc.m_dim_i = 3'd1;
    ifc.signed_i = 1'b0; ifc.bias_en_i = 1'b0;
    ifc.a_i = a1; ifc.b_i = b1; ifc.bias_i = z;
    ifc.start_i = 1'b1;
    @(negedge clk);
    ifc.start_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("run_before_reset_busy", ifc.busy_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_c", ifc.c_o, z);
    chk("abort_ovf", ifc.ovf_o, 0);
    chk("abort_busy", ifc.busy_o, 0);
    chk("abort_done", ifc.done_o, 0);
    chk("abort_err", ifc.err_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(2, 4, 1, 1'b0, 1'b0, a1, b1, z, ec1, '0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
